// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the NOP returned on error requests, and the word range check.
package imem_responder_pkg;

  localparam int IMEM_ADDR_W  = 16;
  localparam int IMEM_INSTR_W = 16;
  localparam logic [IMEM_INSTR_W-1:0] IMEM_NOP = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word index is the byte address without its LSB.
  function automatic logic word_in_range(input logic [IMEM_ADDR_W-2:0] idx,
                                         input int unsigned words);
    return 32'(idx) < words;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: synchronous write, combinational read, no reset
// so that program contents survive a responder reset.
module imem_array #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [15:0]   wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [15:0]   rd_dat
);

  logic [15:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: one outstanding request, response registered LATENCY
// edges after accept and held until rsp_ready; flush/rst abort the request.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_instr,
  output logic [15:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        busy
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  if (LATENCY < 1 || LATENCY > 15 || MEM_WORDS < 2 || MEM_WORDS > 32768) begin : g_param_check
    $error("imem_responder: LATENCY must be 1..15 and MEM_WORDS 2..32768");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_instr_q, rsp_instr_d;
  logic [15:0] rsp_addr_q, rsp_addr_d;
  logic        rsp_err_q, rsp_err_d;

  logic [15:0] rd_dat;
  logic        req_err;
  logic        load_hit;
  logic        unused_load_lsb;

  assign unused_load_lsb = load_addr[0];
  assign load_hit        = load_en & word_in_range(load_addr[15:1], MEM_WORDS);
  assign req_err         = addr_q[0] | ~word_in_range(addr_q[15:1], MEM_WORDS);

  // Read is combinational against pre-write contents, so a same-edge load
  // to the word being fetched returns the old data.
  imem_array #(
    .MEM_WORDS(MEM_WORDS),
    .AW       (AW)
  ) u_array (
    .clk   (clk),
    .wr_en (load_hit),
    .wr_idx(load_addr[AW:1]),
    .wr_dat(load_data),
    .rd_idx(addr_q[AW:1]),
    .rd_dat(rd_dat)
  );

  assign req_ready = (state_q == ST_IDLE) & ~flush & ~load_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;

    if (flush) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_d  = req_addr;
            cnt_d   = 4'(LATENCY);
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_addr_d  = addr_q;
            rsp_err_d   = req_err;
            rsp_instr_d = req_err ? IMEM_NOP : rd_dat;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 16'd0;
      rsp_addr_q  <= 16'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus randomized requests
// checked against a word-array model and a fixed-latency timing rule.
module tb_imem_responder;

  localparam int WORDS = 1024;
  localparam int LAT   = 3;
  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_instr;
  logic [15:0] rsp_addr;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [15:0] load_addr = 16'd0;
  logic [15:0] load_data = 16'd0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [WORDS];
  logic        ref_ok  [WORDS];

  always #5 clk = ~clk;

  imem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  function automatic logic exp_err(input logic [15:0] a);
    return a[0] || (int'(a >> 1) >= WORDS);
  endfunction

  function automatic logic [15:0] exp_instr(input logic [15:0] a);
    return exp_err(a) ? NOP : ref_mem[a >> 1];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
    if (int'(a >> 1) < WORDS) begin
      ref_mem[a >> 1] = d;
      ref_ok[a >> 1]  = 1'b1;
    end
  endtask

  // Issues one request with rsp_ready high; reports what was observed.
  task automatic run_req(input logic [15:0] a, output logic acc, output int lat,
                         output logic [15:0] instr, output logic [15:0] raddr,
                         output logic err, output logic vld_after);
    req_valid = 1'b1; req_addr = a;
    #1 acc = req_ready;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    instr = rsp_instr; raddr = rsp_addr; err = rsp_err;
    step();
    vld_after = rsp_valid;
  endtask

  task automatic check_req(input string name, input logic [15:0] a);
    logic acc, err, va;
    int lat;
    logic [15:0] instr, raddr;
    run_req(a, acc, lat, instr, raddr, err, va);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL %s accept: got %b want 1", name, acc); end
    total++; if (lat != LAT) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, LAT); end
    total++; if (instr !== exp_instr(a)) begin bad++; $display("FAIL %s instr: got %h want %h", name, instr, exp_instr(a)); end
    total++; if (raddr !== a) begin bad++; $display("FAIL %s addr: got %h want %h", name, raddr, a); end
    total++; if (err !== exp_err(a)) begin bad++; $display("FAIL %s err: got %b want %b", name, err, exp_err(a)); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL %s valid after handshake: got %b want 0", name, va); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_instr !== 16'd0) begin bad++; $display("FAIL reset rsp_instr: got %h want 0000", rsp_instr); end
    total++; if (rsp_addr !== 16'd0) begin bad++; $display("FAIL reset rsp_addr: got %h want 0000", rsp_addr); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset rsp_err: got %b want 0", rsp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    step();
  endtask

  task automatic test_basic();
    do_load(16'h0000, 16'h1234);
    do_load(16'h0002, 16'hABCD);
    check_req("basic_0002", 16'h0002);
    check_req("basic_0000", 16'h0000);
  endtask

  task automatic test_error();
    check_req("misaligned", 16'h0003);
    check_req("out_of_range", 16'(2 * WORDS));
    check_req("top_addr", 16'hFFFE);
    do_load(16'(2 * WORDS), 16'hDEAD);
    check_req("dropped_load", 16'h0000);
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    int n;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0002;
    step();
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n != LAT) begin bad++; $display("FAIL bp latency: got %0d want %0d", n, LAT); end
    held = rsp_instr;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp req_ready cyc%0d: got %b want 0", i, req_ready); end
      step();
      total++; if (rsp_valid !== 1'b1 || rsp_instr !== ref_mem[1]) begin
        bad++; $display("FAIL bp hold cyc%0d: got v=%b i=%h want v=1 i=%h", i, rsp_valid, rsp_instr, ref_mem[1]);
      end
    end
    req_valid = 1'b0;
    total++; if (held !== ref_mem[1]) begin bad++; $display("FAIL bp instr: got %h want %h", held, ref_mem[1]); end
    rsp_ready = 1'b1;
    step();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp release: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp req_ready after: got %b want 1", req_ready); end
  endtask

  task automatic test_flush();
    int seen;
    int n;
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_wait busy: got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (rsp_valid === 1'b1) seen++;
      step();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_wait rsp_valid cycles: got %0d want 0", seen); end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
    total++; if (n != LAT) begin bad++; $display("FAIL flush_resp latency: got %0d want %0d", n, LAT); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    rsp_ready = 1'b1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_resp: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_resp req_ready: got %b want 1", req_ready); end
    step();
    check_req("after_flush", 16'h0000);
  endtask

  task automatic test_read_before_write();
    logic [15:0] old;
    old = ref_mem[0];
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    repeat (LAT - 1) step();
    load_en = 1'b1; load_addr = 16'h0000; load_data = 16'h5555;
    step();
    load_en = 1'b0;
    ref_mem[0] = 16'h5555;
    total++; if (rsp_valid !== 1'b1 || rsp_instr !== old) begin
      bad++; $display("FAIL rbw: got v=%b i=%h want v=1 i=%h", rsp_valid, rsp_instr, old);
    end
    step();
    req_valid = 1'b1; req_addr = 16'h0002;
    load_en = 1'b1; load_addr = 16'h0010; load_data = 16'h7777;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL load_blocks req_ready: got %b want 0", req_ready); end
    step();
    req_valid = 1'b0; load_en = 1'b0;
    ref_mem[8] = 16'h7777; ref_ok[8] = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_blocks busy: got %b want 0", busy); end
    check_req("after_rbw", 16'h0000);
    check_req("load_during_idle", 16'h0010);
  endtask

  task automatic test_rst_mid();
    req_valid = 1'b1; req_addr = 16'h0002;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid flags: got v=%b busy=%b err=%b want 0 0 0", rsp_valid, busy, rsp_err);
    end
    total++; if (rsp_instr !== 16'd0 || rsp_addr !== 16'd0) begin
      bad++; $display("FAIL rst_mid data: got i=%h a=%h want 0000 0000", rsp_instr, rsp_addr);
    end
    check_req("retained_0000", 16'h0000);
    check_req("retained_0002", 16'h0002);
  endtask

  task automatic test_random();
    int idx;
    int kind;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(WORDS - 1, 0);
      do_load(16'(idx * 2), 16'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(9, 0);
      do begin idx = $urandom_range(WORDS - 1, 0); end while (!ref_ok[idx]);
      if (kind == 0)      a = 16'(idx * 2 + 1);
      else if (kind == 1) a = 16'($urandom_range(65535, 2 * WORDS));
      else                a = 16'(idx * 2);
      if ($urandom_range(3, 0) == 0) step();
      check_req($sformatf("rand%0d", i), a);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ref_mem[i] = 16'h0000;
      ref_ok[i]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_error();
    test_backpressure();
    test_flush();
    test_read_before_write();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
